// File: rtl/tpu_pkg.sv
// Shared sizing constants and scheduler state encoding for the TPU tile scheduler.
package tpu_pkg;

  localparam int SA_DIM = 4;
  localparam int DIM_W  = 8;
  localparam int IDX_W  = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/tpu_tile_sched_if.sv
// Tile command channel between the scheduler (master) and the systolic-array engine (slave).
interface tpu_tile_sched_if
  import tpu_pkg::*;
  ();

  logic             tile_valid;
  logic             tile_ready;
  logic [DIM_W-1:0] tile_k;
  logic [IDX_W-1:0] a_base;
  logic [IDX_W-1:0] b_base;
  logic [IDX_W-1:0] c_base;
  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] col_cnt;
  logic             tile_done;

  modport master (
    output tile_valid, tile_k, a_base, b_base, c_base, row_cnt, col_cnt,
    input  tile_ready, tile_done
  );

  modport slave (
    input  tile_valid, tile_k, a_base, b_base, c_base, row_cnt, col_cnt,
    output tile_ready, tile_done
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Walks the output tiles (n inner, m outer) and keeps the A/B/C base indices and
// valid row/col counts up to date with adders only.
module tile_addr_gen
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] k,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  output logic [DIM_W-1:0] tile_k,
  output logic [IDX_W-1:0] a_base,
  output logic [IDX_W-1:0] b_base,
  output logic [IDX_W-1:0] c_base,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] col_cnt,
  output logic             last
);

  localparam logic [DIM_W-1:0] SA_D = DIM_W'(SA_DIM);
  localparam logic [IDX_W-1:0] SA_I = IDX_W'(SA_DIM);

  logic [DIM_W-1:0] m_q;
  logic [DIM_W-1:0] n_q;
  // Rows/cols still uncovered from the current tile onwards; they give both the
  // partial-tile counts and the end-of-row / end-of-job conditions.
  logic [DIM_W-1:0] rows_left;
  logic [DIM_W-1:0] cols_left;
  logic [IDX_W-1:0] c_row;
  logic [IDX_W-1:0] k_ext;
  logic [IDX_W-1:0] m_ext;
  logic             n_wrap;

  assign k_ext   = {{(IDX_W-DIM_W){1'b0}}, tile_k};
  assign m_ext   = {{(IDX_W-DIM_W){1'b0}}, m_q};
  assign n_wrap  = (cols_left <= SA_D);
  assign last    = n_wrap && (rows_left <= SA_D);
  assign row_cnt = (rows_left >= SA_D) ? CNT_W'(SA_DIM) : rows_left[CNT_W-1:0];
  assign col_cnt = (cols_left >= SA_D) ? CNT_W'(SA_DIM) : cols_left[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_k    <= '0;
      m_q       <= '0;
      n_q       <= '0;
      rows_left <= '0;
      cols_left <= '0;
      a_base    <= '0;
      b_base    <= '0;
      c_base    <= '0;
      c_row     <= '0;
    end else if (clear) begin
      tile_k    <= k;
      m_q       <= m;
      n_q       <= n;
      rows_left <= m;
      cols_left <= n;
      a_base    <= '0;
      b_base    <= '0;
      c_base    <= '0;
      c_row     <= '0;
    end else if (step) begin
      if (n_wrap) begin
        cols_left <= n_q;
        rows_left <= rows_left - SA_D;
        a_base    <= a_base + k_ext;
        b_base    <= '0;
        c_row     <= c_row + SA_I;
        c_base    <= c_row + SA_I;
      end else begin
        cols_left <= cols_left - SA_D;
        b_base    <= b_base + k_ext;
        c_base    <= c_base + m_ext;
      end
    end
  end

endmodule

// File: rtl/tpu_tile_sched.sv
// Tile scheduler: takes one C = A*B job and issues one command per SA_DIM x SA_DIM
// output tile to the systolic array, waiting for each tile to finish before the next.
module tpu_tile_sched
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DIM_W-1:0] K,
  input  logic [DIM_W-1:0] M,
  input  logic [DIM_W-1:0] N,
  output logic             busy,
  output logic             job_done,
  tpu_tile_sched_if.master tile
);

  sched_state_t state_q;
  sched_state_t state_d;
  logic         clear;
  logic         step;
  logic         last;

  tile_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .step    (step),
    .k       (K),
    .m       (M),
    .n       (N),
    .tile_k  (tile.tile_k),
    .a_base  (tile.a_base),
    .b_base  (tile.b_base),
    .c_base  (tile.c_base),
    .row_cnt (tile.row_cnt),
    .col_cnt (tile.col_cnt),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          clear   = 1'b1;
          state_d = (K == '0 || M == '0 || N == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (tile.tile_ready) state_d = WAIT;
      end
      WAIT: begin
        if (tile.tile_done) begin
          if (last) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so they drop with it on reset.
  assign busy            = (state_q != IDLE);
  assign tile.tile_valid = (state_q == ISSUE);
  assign job_done        = (state_q == DONE);

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Randomised scoreboard bench for tpu_tile_sched with a behavioural SA responder.
module tb_tpu_tile_sched;

  localparam int TB_SA  = 4;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [7:0]  k;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [2:0]  r;
    logic [2:0]  cc;
  } tile_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] K, M, N;
  logic       busy;
  logic       job_done;

  tpu_tile_sched_if tif ();

  tpu_tile_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .K        (K),
    .M        (M),
    .N        (N),
    .busy     (busy),
    .job_done (job_done),
    .tile     (tif)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    hs_cnt  = 0;
  int    done_cnt = 0;
  tile_t exp_q[$];

  int ready_low  = 0;
  int hold_cnt   = 0;
  int done_delay = 3;
  bit ready_tied = 1'b1;
  bit spur_done  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every output tile of the job in (m outer, n inner) order, from plain arithmetic.
  function automatic void push_job(input int k, input int m, input int n);
    tile_t t;
    if (k == 0 || m == 0 || n == 0) return;
    for (int mi = 0; mi < (m + TB_SA - 1) / TB_SA; mi++) begin
      for (int ni = 0; ni < (n + TB_SA - 1) / TB_SA; ni++) begin
        t.k  = 8'(k);
        t.a  = 16'(mi * k);
        t.b  = 16'(ni * k);
        t.c  = 16'(ni * m + mi * TB_SA);
        t.r  = 3'((m - mi * TB_SA) < TB_SA ? (m - mi * TB_SA) : TB_SA);
        t.cc = 3'((n - ni * TB_SA) < TB_SA ? (n - ni * TB_SA) : TB_SA);
        exp_q.push_back(t);
      end
    end
  endfunction

  function automatic tile_t cur_tile();
    tile_t t;
    t.k  = tif.tile_k;
    t.a  = tif.a_base;
    t.b  = tif.b_base;
    t.c  = tif.c_base;
    t.r  = tif.row_cnt;
    t.cc = tif.col_cnt;
    return t;
  endfunction

  // Monitor: compares each accepted command against the scoreboard and checks hold stability.
  initial begin : monitor
    tile_t cur;
    tile_t held;
    bit    prev_hold;
    prev_hold = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        cur = cur_tile();
        if (prev_hold && tif.tile_valid) check("hold_stable", 64'(cur), 64'(held));
        if (tif.tile_valid && tif.tile_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tile_unexpected: got %0h expected no tile", cur);
          end else begin
            check("tile", 64'(cur), 64'(exp_q.pop_front()));
          end
        end
        prev_hold = tif.tile_valid && !tif.tile_ready;
        held      = cur;
        if (job_done) begin
          done_cnt++;
          check("busy_at_done", 64'(busy), 64'(1));
          check("tiles_left_at_done", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  end

  // Systolic-array responder: handshakes, then pulses tile_done after done_delay cycles.
  initial begin : sa_model
    int pend;
    bit hs;
    pend           = 0;
    tif.tile_ready = 1'b0;
    tif.tile_done  = 1'b0;
    forever begin
      @(negedge clk);
      hs = rst_n && tif.tile_valid && tif.tile_ready;
      @(posedge clk);
      #1;
      tif.tile_done = 1'b0;
      if (ready_tied) tif.tile_ready = 1'b1;
      else if (!tif.tile_valid && pend == 0 && !hs) tif.tile_ready = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (hs) begin
        tif.tile_ready = ready_tied;
        hold_cnt       = ready_low;
        pend           = done_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) tif.tile_done = 1'b1;
      end else if (tif.tile_valid && !tif.tile_ready) begin
        if (hold_cnt > 0) begin
          hold_cnt--;
          tif.tile_done = spur_done;
        end else begin
          tif.tile_ready = 1'b1;
        end
      end
    end
  end

  task automatic start_job(input int k, input int m, input int n);
    @(posedge clk);
    #1;
    push_job(k, m, n);
    in_valid = 1'b1;
    K = 8'(k);
    M = 8'(m);
    N = 8'(n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    K = 8'($urandom);
    M = 8'($urandom);
    N = 8'($urandom);
  endtask

  task automatic run_job(input int k, input int m, input int n, input int rlow, input bit tied,
                         input int dly, input bit spur_inv, input bit spur_dn);
    int d0;
    int h0;
    ready_low  = rlow;
    hold_cnt   = rlow;
    ready_tied = tied;
    done_delay = dly;
    spur_done  = spur_dn;
    d0 = done_cnt;
    h0 = hs_cnt;
    start_job(k, m, n);
    if (spur_inv) begin
      for (int i = 0; i < BUDGET; i++) begin
        if (hs_cnt != h0) break;
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      K = 8'd2;
      M = 8'd2;
      N = 8'd2;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #2;
      if (done_cnt != d0) break;
    end
    check("job_done_once", 64'(done_cnt), 64'(d0 + 1));
    check("busy_after_done", 64'(busy), 64'(0));
    check("job_done_pulse", 64'(job_done), 64'(0));
    check("valid_after_done", 64'(tif.tile_valid), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    if (k == 0 || m == 0 || n == 0) check("zero_job_no_tile", 64'(hs_cnt), 64'(h0));
  endtask

  initial begin : main
    int h0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    K = '0;
    M = '0;
    N = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(tif.tile_valid), 64'(0));
    check("rst_job_done", 64'(job_done), 64'(0));
    check("rst_fields", 64'(cur_tile()), 64'(0));
    rst_n = 1'b1;

    run_job(8, 8, 8, 0, 1'b1, 3, 1'b0, 1'b0);
    run_job(3, 5, 6, 0, 1'b1, 3, 1'b0, 1'b0);
    run_job(4, 0, 4, 0, 1'b1, 3, 1'b0, 1'b0);
    run_job(0, 7, 7, 0, 1'b1, 3, 1'b0, 1'b0);
    run_job(5, 9, 6, 5, 1'b0, 2, 1'b0, 1'b0);
    run_job(6, 6, 10, 0, 1'b1, 3, 1'b1, 1'b0);
    run_job(7, 10, 5, 2, 1'b0, 3, 1'b0, 1'b1);
    run_job(1, 1, 1, 0, 1'b1, 1, 1'b0, 1'b0);
    run_job(255, 13, 17, 1, 1'b0, 2, 1'b0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 20), $urandom_range(1, 14), $urandom_range(1, 14),
              $urandom_range(0, 3), 1'b0, $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the second tile, then a fresh job must start at tile (0,0).
    ready_tied = 1'b1;
    ready_low  = 0;
    hold_cnt   = 0;
    done_delay = 4;
    spur_done  = 1'b0;
    h0 = hs_cnt;
    start_job(8, 8, 8);
    for (int i = 0; i < BUDGET; i++) begin
      if (hs_cnt == h0 + 2) break;
      @(posedge clk);
      #1;
    end
    check("reset_test_reached_tile2", 64'(hs_cnt), 64'(h0 + 2));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_valid", 64'(tif.tile_valid), 64'(0));
    check("arst_job_done", 64'(job_done), 64'(0));
    check("arst_fields", 64'(cur_tile()), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_job(8, 8, 8, 0, 1'b1, 3, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
